// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;

    // Counter must index WIDTH-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle between a requester and seq_multiplier.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   signed_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mult_abs.sv
// Conditional two's-complement negation; yields a magnitude when negate is the sign bit.
module mult_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);
    assign result = negate ? (W'(0) - value) : value;
endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one WIDTH+1 bit add per cycle, signed via magnitudes.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    state_t             state_q, state_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      product_q, product_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum_c;
    logic [PW-1:0]      acc_step;
    logic [PW-1:0]      acc_signed;
    logic               last_c;

    mult_abs #(.W(WIDTH)) u_abs_a (
        .value  (bus.a),
        .negate (bus.signed_mode & bus.a[WIDTH-1]),
        .result (mag_a)
    );

    mult_abs #(.W(WIDTH)) u_abs_b (
        .value  (bus.b),
        .negate (bus.signed_mode & bus.b[WIDTH-1]),
        .result (mag_b)
    );

    // Add into the upper half keeping the carry, then shift the whole accumulator right.
    assign sum_c    = (WIDTH+1)'(acc_q[PW-1:WIDTH]) + (mb_q[0] ? (WIDTH+1)'(ma_q) : '0);
    assign acc_step = PW'({sum_c, acc_q[WIDTH-1:0]} >> 1);
    assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));

    // Result sign is applied to the final step so product is registered on DONE entry.
    mult_abs #(.W(PW)) u_neg_res (
        .value  (acc_step),
        .negate (neg_q),
        .result (acc_signed)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    ma_d    = mag_a;
                    mb_d    = mag_b;
                    neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_step;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_c) begin
                    product_d = acc_signed;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: arithmetic/timing model on the W=8 instance plus directed literals.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(8)) bus8 ();
    seq_multiplier_if #(.WIDTH(4)) bus4 ();

    seq_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    seq_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [15:0] expect8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int sa, sb;
        sa = sm ? int'($signed(a)) : int'(a);
        sb = sm ? int'($signed(b)) : int'(b);
        return 16'(sa * sb);
    endfunction

    // Transaction-level model: idle / busy for WIDTH edges / result held until taken.
    typedef enum {M_IDLE, M_CALC, M_DONE} mph_t;
    mph_t        ph = M_IDLE;
    int          m_rem = 0;
    logic [15:0] m_exp = '0;
    logic [15:0] m_prod = '0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph     = M_IDLE;
            m_prod = '0;
            m_live = 1'b1;
        end else begin
            case (ph)
                M_IDLE: if (bus8.in_valid) begin
                    m_exp = expect8(bus8.a, bus8.b, bus8.signed_mode);
                    m_rem = 8;
                    ph    = M_CALC;
                end
                M_CALC: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        ph     = M_DONE;
                        m_prod = m_exp;
                    end
                end
                M_DONE: if (bus8.out_ready) ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("mdl_in_ready",  32'(bus8.in_ready),  32'(ph == M_IDLE));
            chk("mdl_busy",      32'(bus8.busy),      32'(ph != M_IDLE));
            chk("mdl_out_valid", 32'(bus8.out_valid), 32'(ph == M_DONE));
            if (ph == M_DONE) chk("mdl_product", 32'(bus8.product), 32'(m_prod));
        end
    end

    // Present one operand pair on an idle W=8 block, check latency and literal product, then take it.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input string name);
        int cyc;
        bus8.a = a; bus8.b = b; bus8.signed_mode = sm; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.signed_mode = ~sm;
        cyc = 1;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_lat"}, 32'(cyc), 32'd9);
        chk(name, 32'(bus8.product), 32'(exp));
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        chk({name, "_idle"}, 32'(bus8.in_ready), 32'd1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic [7:0] exp, input string name);
        int cyc;
        bus4.a = a; bus4.b = b; bus4.signed_mode = sm; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        cyc = 1;
        while (!bus4.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_lat"}, 32'(cyc), 32'd5);
        chk(name, 32'(bus4.product), 32'(exp));
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        chk({name, "_idle"}, 32'(bus4.in_ready), 32'd1);
        chk({name, "_drop"}, 32'(bus4.out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;
        bus8.in_valid = 1'b1; bus8.a = 8'd3; bus8.b = 8'd4; bus8.signed_mode = 1'b0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b1; bus4.a = 4'd3; bus4.b = 4'd4; bus4.signed_mode = 1'b0; bus4.out_ready = 1'b0;
        rst_n = 1'b0;

        // Reset held three cycles with in_valid asserted.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_product",   32'(bus8.product),   32'd0);
        chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
        chk("rst_busy",      32'(bus8.busy),      32'd0);
        chk("rst4_product",  32'(bus4.product),   32'd0);
        chk("rst4_busy",     32'(bus4.busy),      32'd0);
        bus8.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

        op4(4'hF, 4'hF, 1'b0, 8'hE1, "u4_15x15");
        op4(4'h8, 4'h8, 1'b1, 8'h40, "s4_m8xm8");

        op8(8'hFD, 8'h07, 1'b1, 16'hFFEB, "s8_m3x7");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s8_m128xm128");
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s8_m128x127");
        op8(8'hFF, 8'h02, 1'b0, 16'h01FE, "u8_255x2");
        op8(8'hFF, 8'h02, 1'b1, 16'hFFFE, "s8_m1x2");
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u8_255x255");
        op8(8'h00, 8'h00, 1'b1, 16'h0000, "s8_zero");
        op8(8'h7F, 8'h81, 1'b1, 16'hC0FF, "s8_127xm127");

        // Consumer already ready when the result appears: one-cycle out_valid.
        bus8.out_ready = 1'b1;
        bus8.a = 8'h0C; bus8.b = 8'h0D; bus8.signed_mode = 1'b0; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        cyc = 1;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("rdy_hi_lat", 32'(cyc), 32'd9);
        chk("rdy_hi_product", 32'(bus8.product), 32'h009C);
        @(negedge clk);
        chk("rdy_hi_pulse", 32'(bus8.out_valid), 32'd0);
        chk("rdy_hi_in_ready", 32'(bus8.in_ready), 32'd1);
        bus8.out_ready = 1'b0;

        // Back-pressure: result held ten cycles while a new request is offered.
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.signed_mode = 1'b0; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        cyc = 1;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_lat", 32'(cyc), 32'd9);
        bus8.a = 8'd6; bus8.b = 8'd9; bus8.signed_mode = 1'b0; bus8.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_product", 32'(bus8.product), 32'h03A8);
            chk("bp_hold_in_ready", 32'(bus8.in_ready), 32'd0);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(bus8.in_ready), 32'd1);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        chk("bp_next_accepted", 32'(bus8.busy), 32'd1);
        cyc = 1;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_next_lat", 32'(cyc), 32'd9);
        chk("bp_next_product", 32'(bus8.product), 32'h0036);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;

        // Reset during CALC discards the operation.
        bus8.a = 8'h55; bus8.b = 8'h33; bus8.signed_mode = 1'b0; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_busy", 32'(bus8.busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus8.out_valid) seen++;
        end
        chk("rst_mid_no_valid", 32'(seen), 32'd0);
        op8(8'd6, 8'd9, 1'b0, 16'h0036, "after_rst_6x9");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
